// File: rtl/hazard_pkg.sv
// hazard_pkg: shared opcodes, FSM state type and hazard cause encodings
package hazard_pkg;
  localparam logic [5:0] BEQ_OP = 6'b000100;
  localparam logic [5:0] BNE_OP = 6'b000101;
  typedef enum logic {IDLE, STALL} state_t;
  localparam logic [1:0] HZ_NONE   = 2'd0;
  localparam logic [1:0] HZ_LOAD   = 2'd1;
  localparam logic [1:0] HZ_BRANCH = 2'd2;
  localparam logic [1:0] HZ_MEM    = 2'd3;
endpackage

// File: rtl/hazard_reg_match.sv
// hazard_reg_match: one source-vs-destination compare; register 0 never matches
// Ports: src, dst (REG_AW) in; hit out
module hazard_reg_match #(
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [REG_AW-1:0] dst,
  output logic              hit
);
  assign hit = (src == dst) && (dst != '0);
endmodule

// File: rtl/hazard_ctrl_unit.sv
// hazard_ctrl_unit: load-use / branch-data / memory-wait stall, flush and stall counting
// Ports: clk, reset (sync, active-high); EX/MEM/ID pipeline fields, branch_taken, mem_busy in;
//        holdPC, holdIF_ID, muxSelector, flushIF_ID, freeze, hazard_type[1:0] (combinational),
//        stall_cycles[PERF_W-1:0] (registered, saturating) out
module hazard_ctrl_unit #(
  parameter int REG_AW = 5,
  parameter int OP_W = 6,
  parameter logic [OP_W-1:0] BEQ_OP = OP_W'(hazard_pkg::BEQ_OP),
  parameter logic [OP_W-1:0] BNE_OP = OP_W'(hazard_pkg::BNE_OP),
  parameter int LOAD_STALL = 1,
  parameter int PERF_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ID_Ex_MemRead,
  input  logic              ID_Ex_RegWrite,
  input  logic [REG_AW-1:0] ID_Ex_Rd,
  input  logic              Ex_Mem_MemRead,
  input  logic [REG_AW-1:0] Ex_Mem_Rd,
  input  logic [OP_W-1:0]   IF_ID_Op,
  input  logic [REG_AW-1:0] IF_ID_Rs,
  input  logic [REG_AW-1:0] IF_ID_Rt,
  input  logic              IF_ID_UsesRt,
  input  logic              branch_taken,
  input  logic              mem_busy,
  output logic              holdPC,
  output logic              holdIF_ID,
  output logic              muxSelector,
  output logic              flushIF_ID,
  output logic              freeze,
  output logic [1:0]        hazard_type,
  output logic [PERF_W-1:0] stall_cycles
);
  import hazard_pkg::*;
  logic ex_rs, ex_rt, mem_rs, mem_rt;
  hazard_reg_match #(.REG_AW(REG_AW)) m_ex_rs (.src(IF_ID_Rs), .dst(ID_Ex_Rd), .hit(ex_rs));
  hazard_reg_match #(.REG_AW(REG_AW)) m_ex_rt (.src(IF_ID_Rt), .dst(ID_Ex_Rd), .hit(ex_rt));
  hazard_reg_match #(.REG_AW(REG_AW)) m_mem_rs (.src(IF_ID_Rs), .dst(Ex_Mem_Rd), .hit(mem_rs));
  hazard_reg_match #(.REG_AW(REG_AW)) m_mem_rt (.src(IF_ID_Rt), .dst(Ex_Mem_Rd), .hit(mem_rt));
  logic       load_use, is_branch, ex_any, mem_any, stall;
  logic [1:0] lu_len, br_len, need_len, det_type, cnt, cnt_n;
  state_t     state, state_n;
  // branches compare in ID, so they always read both rs and rt
  assign ex_any    = ex_rs || ex_rt;
  assign mem_any   = mem_rs || mem_rt;
  assign load_use  = ID_Ex_MemRead && (ex_rs || (ex_rt && IF_ID_UsesRt));
  assign is_branch = (IF_ID_Op == BEQ_OP) || (IF_ID_Op == BNE_OP);
  assign lu_len    = load_use ? 2'(LOAD_STALL) : 2'd0;
  assign br_len    = !is_branch ? 2'd0
                   : (ID_Ex_MemRead && ex_any) ? 2'd2
                   : ((ID_Ex_RegWrite && ex_any) || (Ex_Mem_MemRead && mem_any)) ? 2'd1 : 2'd0;
  assign need_len  = (lu_len >= br_len) ? lu_len : br_len;
  // load-use wins ties against branch
  assign det_type  = (lu_len != 2'd0 && lu_len >= br_len) ? HZ_LOAD
                   : (br_len != 2'd0) ? HZ_BRANCH : HZ_NONE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= 2'd0;
      stall_cycles <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (holdPC && stall_cycles != '1) stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end
  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    stall       = 1'b0;
    freeze      = 1'b0;
    hazard_type = HZ_NONE;
    if (reset) begin
      state_n = IDLE;
      cnt_n   = 2'd0;
    end else if (mem_busy) begin
      freeze      = 1'b1;
      hazard_type = HZ_MEM;
    end else if (state == STALL) begin
      stall       = 1'b1;
      hazard_type = det_type;
      cnt_n       = cnt - 2'd1;
      state_n     = (cnt == 2'd1) ? IDLE : STALL;
    end else if (need_len != 2'd0) begin
      stall       = 1'b1;
      hazard_type = det_type;
      cnt_n       = need_len - 2'd1;
      state_n     = (need_len > 2'd1) ? STALL : IDLE;
    end
    holdPC      = stall || freeze;
    holdIF_ID   = stall || freeze;
    muxSelector = stall;
    flushIF_ID  = !reset && branch_taken && !stall && !mem_busy;
  end
endmodule

// File: doc/hazard_ctrl_unit.md
HAZARD_CTRL_UNIT -- requirements
Module: hazard_ctrl_unit

Interface
REQ-001 Parameters SHALL be: REG_AW, default 5, register-address width; OP_W, default 6, opcode width; BEQ_OP, default 6'b000100, branch-equal opcode; BNE_OP, default 6'b000101, branch-not-equal opcode; LOAD_STALL, default 1, load-use stall cycles, range 1..3; PERF_W, default 16, stall-counter width.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 The ports SHALL be, in order (name  direction  width  meaning):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- ID_Ex_MemRead  in  1  instruction in EX is a load
- ID_Ex_RegWrite  in  1  instruction in EX writes a register
- ID_Ex_Rd  in  REG_AW  EX destination register, after the RegDst mux
- Ex_Mem_MemRead  in  1  instruction in MEM is a load
- Ex_Mem_Rd  in  REG_AW  MEM destination register
- IF_ID_Op  in  OP_W  opcode in ID
- IF_ID_Rs  in  REG_AW  rs in ID
- IF_ID_Rt  in  REG_AW  rt in ID
- IF_ID_UsesRt  in  1  ID instruction reads rt
- branch_taken  in  1  branch in ID resolved taken
- mem_busy  in  1  data memory wait
- holdPC  out  1  hold PC
- holdIF_ID  out  1  hold IF/ID register
- muxSelector  out  1  zero the ID/EX control signals (bubble)
- flushIF_ID  out  1  clear IF/ID register
- freeze  out  1  hold all pipeline registers
- hazard_type  out  2  cause: 0 none, 1 load-use, 2 branch data, 3 memory wait
- stall_cycles  out  PERF_W  saturating count of stall cycles

Function
REQ-004 A source SHALL match a destination only when the addresses are equal and the destination is not 0; register 0 SHALL never create a hazard.
REQ-005 A load-use hazard SHALL exist when ID_Ex_MemRead=1 and ID_Ex_Rd matches IF_ID_Rs, or matches IF_ID_Rt while IF_ID_UsesRt=1; the required stall length is LOAD_STALL.
REQ-006 A branch hazard SHALL exist only when IF_ID_Op equals BEQ_OP or BNE_OP, and its required stall length SHALL be:
- 1 for an ALU producer in EX (ID_Ex_RegWrite=1, ID_Ex_MemRead=0) with a matching Rd;
- 2 for a load in EX with a matching Rd;
- 1 for a load in MEM with a matching Ex_Mem_Rd.
REQ-007 If several hazards exist in the same cycle, the block SHALL use the longest required stall length; hazard_type SHALL report load-use ahead of branch when the lengths are equal.
REQ-008 The FSM SHALL have two states, IDLE and STALL, plus a 2-bit remaining-cycle counter cnt.
REQ-009 In IDLE with a hazard of stall length N, the block SHALL assert holdPC, holdIF_ID and muxSelector in the same cycle (zero latency); when N>1 it SHALL load cnt=N-1 and enter STALL, otherwise it SHALL stay in IDLE.
REQ-010 In STALL, the block SHALL assert holdPC, holdIF_ID and muxSelector unconditionally, decrement cnt each cycle, and return to IDLE on the cycle in which cnt=1.
REQ-011 While mem_busy=1, freeze, holdPC and holdIF_ID SHALL be 1; muxSelector and flushIF_ID SHALL be 0; hazard_type SHALL be 3; state and cnt SHALL hold; hazard detection SHALL be ignored.
REQ-012 flushIF_ID SHALL be 1 only when branch_taken=1, no stall is asserted that cycle and mem_busy=0; it SHALL last exactly one cycle per taken branch.
REQ-013 stall_cycles SHALL increment on every cycle in which holdPC=1 and SHALL saturate at all ones without wrapping.
REQ-014 In any cycle with no stall, no freeze and no hazard, holdPC, holdIF_ID, muxSelector, freeze and hazard_type SHALL all be 0.

Reset
REQ-015 While reset=1 on a clock edge, the block SHALL set state=IDLE, cnt=0 and stall_cycles=0.
REQ-016 While reset=1, all control outputs SHALL be 0 combinationally; a stall in progress SHALL be abandoned with no residual hold after reset releases.

Structure
REQ-017 A shared package hazard_pkg SHALL hold BEQ_OP, BNE_OP, the IDLE/STALL state enum and the hazard_type encodings.
REQ-018 The block SHALL contain one sub-module, hazard_reg_match, which compares one source against one destination with the register-0 exclusion; it SHALL be instantiated per comparison.
REQ-019 All outputs other than stall_cycles SHALL be combinational from state, cnt and the inputs; state, cnt and stall_cycles SHALL be registered.

Verification
REQ-020 The bench SHALL cover each of the following directed scenarios:
- LOAD_STALL=1, load in EX with Rd=8, ID add with Rs=8 -> holdPC=holdIF_ID=muxSelector=1 for exactly 1 cycle, hazard_type=1.
- LOAD_STALL=3, same stimulus -> stall for exactly 3 cycles, then 0; stall_cycles advances by 3.
- BEQ in ID with Rs=9 and a load in EX with Rd=9 -> 2 stall cycles, hazard_type=2; the same case with an ALU producer -> 1 cycle.
- Load in EX with Rd=0, ID Rs=0 -> no stall; branch_taken=1 with no hazard -> flushIF_ID=1 for 1 cycle.
- mem_busy=1 for 4 cycles in the middle of a 3-cycle stall -> freeze=1 for 4 cycles, muxSelector=0, cnt preserved, remaining stall cycles completed afterwards.
- reset=1 asserted during STALL -> all outputs 0 the same cycle, state=IDLE next cycle; stall_cycles preset near max -> saturates at 16'hFFFF.
